// File: rtl/ahbl_splitter_n.sv
// AHB-Lite address decoder / response mux for NS slaves with a two-cycle ERROR for unmapped space.
// Optional stall watchdog compiled in with `define AHBL_SPLITTER_TIMEOUT_EN.
module ahbl_splitter_n #(
    parameter int NS      = 3,
    parameter int DEC_LSB = 24,
    parameter int TIMEOUT = 255
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HREADY,
    input  logic             HSEL,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [NS-1:0]    S_HSEL,
    input  logic [NS-1:0]    S_HREADYOUT,
    input  logic [NS-1:0]    S_HRESP,
    input  logic [32*NS-1:0] S_HRDATA,
    output logic             TO_PULSE
);

    localparam logic [31:0] DEFAULT_RDATA = 32'hBADD_BEEF;
    localparam logic [4:0]  NS_W          = 5'(NS);

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} err_state_t;

    err_state_t  state, state_nxt;
    logic [3:0]  dec;
    logic        in_map;
    logic        unmapped_xfer;
    logic        owner_vld;
    logic [3:0]  owner_idx;
    logic        slv_ready;
    logic        slv_resp;
    logic [31:0] slv_rdata;
    logic        timeout_hit;
    logic        unused_bits;

    assign dec           = HADDR[DEC_LSB+3:DEC_LSB];
    assign in_map        = ({1'b0, dec} < NS_W);
    assign unmapped_xfer = HSEL && HREADY && HTRANS[1] && !in_map;
    assign unused_bits   = ^{HADDR, HTRANS[0], 16'(TIMEOUT)};

    always_comb begin
        S_HSEL = '0;
        for (int i = 0; i < NS; i++) begin
            S_HSEL[i] = HSEL && (dec == 4'(i));
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        slv_rdata = DEFAULT_RDATA;
        for (int i = 0; i < NS; i++) begin
            if (owner_vld && owner_idx == 4'(i)) begin
                slv_ready = S_HREADYOUT[i];
                slv_resp  = S_HRESP[i];
                slv_rdata = S_HRDATA[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (unmapped_xfer) state_nxt = ERR1;
            ERR1:    state_nxt = ERR2;
            ERR2:    state_nxt = unmapped_xfer ? ERR1 : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = ERR1;
    end

    always_comb begin
        HREADYOUT = slv_ready;
        HRESP     = slv_resp;
        HRDATA    = slv_rdata;
        case (state)
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                HRDATA    = DEFAULT_RDATA;
            end
            ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
                HRDATA    = DEFAULT_RDATA;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            owner_vld <= 1'b0;
            owner_idx <= '0;
        end else begin
            state <= state_nxt;
            if (timeout_hit) begin
                owner_vld <= 1'b0;
            end else if (HREADY) begin
                owner_vld <= HSEL && in_map;
                owner_idx <= dec;
            end
        end
    end

`ifdef AHBL_SPLITTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] stall_cnt;
    logic        stalled;
    logic        to_pulse_q;

    assign stalled     = owner_vld && !HREADYOUT;
    // Fires on the edge that closes the TIMEOUT-th stalled cycle.
    assign timeout_hit = stalled && (stall_cnt >= TIMEOUT_W - 16'd1);
    assign TO_PULSE    = to_pulse_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            stall_cnt  <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= timeout_hit;
            if (timeout_hit || !stalled) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign TO_PULSE    = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n (NS=3, TIMEOUT=4); HREADY is looped back from HREADYOUT.
module tb_ahbl_splitter_n;

    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_BUSY   = 2'b01;
    localparam logic [1:0]  T_NSEQ   = 2'b10;
    localparam logic [31:0] BAD      = 32'hBADD_BEEF;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [2:0]  s_hsel;
    logic [2:0]  s_hreadyout;
    logic [2:0]  s_hresp;
    logic [95:0] s_hrdata;
    logic        to_pulse;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    ahbl_splitter_n #(.NS(3), .DEC_LSB(24), .TIMEOUT(4)) dut (
        .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans),
        .HREADY(hready), .HSEL(hsel), .HREADYOUT(hreadyout), .HRESP(hresp),
        .HRDATA(hrdata), .S_HSEL(s_hsel), .S_HREADYOUT(s_hreadyout),
        .S_HRESP(s_hresp), .S_HRDATA(s_hrdata), .TO_PULSE(to_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
        hsel   = sel;
        htrans = trans;
        haddr  = addr;
        #1;
    endtask

    task automatic check_bus(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
        check({tag, "_hreadyout"}, 32'(hreadyout), 32'(rdy));
        check({tag, "_hresp"},     32'(hresp),     32'(rsp));
        check({tag, "_hrdata"},    hrdata,         rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        hreset      = 1'b1;
        s_hreadyout = 3'b111;
        s_hresp     = 3'b000;
        s_hrdata    = {32'hC2C2_C2C2, 32'h1111_1111, 32'hA0A0_0000};
        drive(1'b0, T_IDLE, 32'h0);

        // Reset state; S_HSEL stays combinational during reset.
        step();
        drive(1'b1, T_NSEQ, 32'h0200_0000);
        check_bus("reset", 1'b1, 1'b0, BAD);
        check("reset_to_pulse", 32'(to_pulse), 32'd0);
        check("reset_s_hsel", 32'(s_hsel), 32'b100);
        hreset = 1'b0;
        drive(1'b0, T_IDLE, 32'h0);
        step();

        // Read slave 1 with two wait states; owner must hold across the stall.
        s_hreadyout[1] = 1'b0;
        drive(1'b1, T_NSEQ, 32'h0100_0000);
        check("rd1_addr_s_hsel", 32'(s_hsel), 32'b010);
        check("rd1_addr_ready", 32'(hreadyout), 32'd1);
        step();
        drive(1'b1, T_IDLE, 32'h0000_0000);
        check("rd1_wait1_ready", 32'(hreadyout), 32'd0);
        step();
        check("rd1_wait2_hold", 32'(hreadyout), 32'd0);
        step();
        s_hreadyout[1]  = 1'b1;
        s_hrdata[63:32] = 32'h1234_5678;
        drive(1'b0, T_IDLE, 32'h0);
        check_bus("rd1_done", 1'b1, 1'b0, 32'h1234_5678);
        step();
        check_bus("rd1_after", 1'b1, 1'b0, BAD);

        // Unmapped NONSEQ: two-cycle ERROR.
        drive(1'b1, T_NSEQ, 32'h0500_0000);
        check("unm_s_hsel", 32'(s_hsel), 32'b000);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        check_bus("unm_err1", 1'b0, 1'b1, BAD);
        step();
        check_bus("unm_err2", 1'b1, 1'b1, BAD);
        step();
        check_bus("unm_idle", 1'b1, 1'b0, BAD);

        // IDLE and BUSY to unmapped space are zero-wait OKAY.
        drive(1'b1, T_IDLE, 32'h0500_0000);
        step();
        check_bus("unm_idle_xfer", 1'b1, 1'b0, BAD);
        drive(1'b1, T_BUSY, 32'h0500_0000);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        check_bus("unm_busy_xfer", 1'b1, 1'b0, BAD);

        // Unmapped then a slave-0 read presented in ERR2: no bubble.
        drive(1'b1, T_NSEQ, 32'h0500_0000);
        step();
        s_hrdata[31:0] = 32'hA0A0_0001;
        drive(1'b1, T_NSEQ, 32'h0000_0000);
        check_bus("b2b_err1", 1'b0, 1'b1, BAD);
        step();
        check_bus("b2b_err2", 1'b1, 1'b1, BAD);
        check("b2b_s_hsel", 32'(s_hsel), 32'b001);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        check_bus("b2b_slave0", 1'b1, 1'b0, 32'hA0A0_0001);
        step();

        // Unmapped in ERR2 (decode == NS boundary) re-enters ERR1.
        drive(1'b1, T_NSEQ, 32'h0F00_0000);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        step();
        drive(1'b1, T_NSEQ, 32'h0300_0000);
        check_bus("rerr_err2", 1'b1, 1'b1, BAD);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        check_bus("rerr_err1", 1'b0, 1'b1, BAD);
        step();
        step();
        check_bus("rerr_idle", 1'b1, 1'b0, BAD);

        // Slave 2 stalls forever.
        s_hreadyout[2] = 1'b0;
        drive(1'b1, T_NSEQ, 32'h0200_0000);
        check("st_s_hsel", 32'(s_hsel), 32'b100);
        step();
        drive(1'b0, T_IDLE, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("st_c%0d_ready", c), 32'(hreadyout), 32'd0);
            check($sformatf("st_c%0d_pulse", c), 32'(to_pulse), 32'd0);
            step();
        end
`ifdef AHBL_SPLITTER_TIMEOUT_EN
        check_bus("to_err1", 1'b0, 1'b1, BAD);
        check("to_err1_pulse", 32'(to_pulse), 32'd1);
        step();
        check_bus("to_err2", 1'b1, 1'b1, BAD);
        check("to_err2_pulse", 32'(to_pulse), 32'd0);
        step();
        check_bus("to_idle", 1'b1, 1'b0, BAD);
`else
        check("st_c5_ready", 32'(hreadyout), 32'd0);
        check("st_c5_pulse", 32'(to_pulse), 32'd0);
        step();
        step();
        check("st_c7_ready", 32'(hreadyout), 32'd0);
`endif

        // Reset in the middle of a stall.
        drive(1'b1, T_NSEQ, 32'h0200_0000);
        step();
        check("rst_stall_pre", 32'(hreadyout), 32'd0);
        hreset = 1'b1;
        step();
        check_bus("rst_stall", 1'b1, 1'b0, BAD);
        check("rst_stall_pulse", 32'(to_pulse), 32'd0);
        check("rst_stall_s_hsel", 32'(s_hsel), 32'b100);
        hreset      = 1'b0;
        s_hreadyout = 3'b111;
        drive(1'b0, T_IDLE, 32'h0);
        step();

        // Reset in the middle of ERR1.
        drive(1'b1, T_NSEQ, 32'h0500_0000);
        step();
        check("rst_err1_pre", 32'(hreadyout), 32'd0);
        hreset = 1'b1;
        drive(1'b0, T_IDLE, 32'h0);
        step();
        check_bus("rst_err1", 1'b1, 1'b0, BAD);
        check("rst_err1_pulse", 32'(to_pulse), 32'd0);
        hreset = 1'b0;
        step();
        check_bus("post_rst", 1'b1, 1'b0, BAD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
